// File: rtl/hd44780_nybble_sender.sv
// HD44780 4-bit write engine: latches one nybble plus RS on a start strobe,
// then drives the LCD pins through setup, E-high and hold phases so every
// write meets tAS, PWEH and tcycE, ending with a one-cycle end strobe.

`ifndef H4NS_TICKS_TAS
`define H4NS_TICKS_TAS 3
`endif
`ifndef H4NS_TICKS_PWEH
`define H4NS_TICKS_PWEH 22
`endif
`ifndef H4NS_TICKS_TCYCE
`define H4NS_TICKS_TCYCE 48
`endif
`ifndef H4NS_COUNT_BITS
`define H4NS_COUNT_BITS 6
`endif

module hd44780_nybble_sender #(
  parameter int TICKS_TAS   = `H4NS_TICKS_TAS,
  parameter int TICKS_PWEH  = `H4NS_TICKS_PWEH,
  parameter int TICKS_TCYCE = `H4NS_TICKS_TCYCE,
  parameter int COUNT_BITS  = `H4NS_COUNT_BITS
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic [3:0] DAT_I,
  input  logic       rs_i,
  input  logic       start_strobe,
  output logic       busy,
  output logic       end_strobe,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [3:0] lcd_data
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EPULSE,
    HOLD,
    DONE
  } state_t;

  // Each phase lasts (load value + 1) cycles; HOLD absorbs the remainder of tcycE.
  localparam int HOLD_TICKS = TICKS_TCYCE - TICKS_TAS - TICKS_PWEH;

  localparam logic [COUNT_BITS-1:0] LOAD_SETUP  = COUNT_BITS'(TICKS_TAS - 1);
  localparam logic [COUNT_BITS-1:0] LOAD_EPULSE = COUNT_BITS'(TICKS_PWEH - 1);
  localparam logic [COUNT_BITS-1:0] LOAD_HOLD   = COUNT_BITS'(HOLD_TICKS - 1);

  // Elaboration-time guard against timing parameters that cannot be honoured.
  if (TICKS_TAS < 1 || TICKS_PWEH < 1 ||
      TICKS_TCYCE < TICKS_TAS + TICKS_PWEH + 1 ||
      TICKS_TCYCE >= (1 << COUNT_BITS)) begin : g_bad_params
    $error("hd44780_nybble_sender: illegal timing parameters");
  end

  state_t                  state;
  state_t                  state_next;
  logic [COUNT_BITS-1:0]   count;
  logic [COUNT_BITS-1:0]   count_next;
  logic [3:0]              data_next;
  logic                    rs_next;
  logic                    busy_next;
  logic                    end_next;
  logic                    e_next;

  // Next-state, counter reload and next-output decode; outputs are derived
  // from the next state so the pins change on the same edge as the state.
  always_comb begin
    state_next = state;
    count_next = count;
    data_next  = lcd_data;
    rs_next    = lcd_rs;

    case (state)
      IDLE, DONE: begin
        if (start_strobe) begin
          state_next = SETUP;
          count_next = LOAD_SETUP;
          data_next  = DAT_I;
          rs_next    = rs_i;
        end else begin
          state_next = IDLE;
          count_next = '0;
        end
      end
      SETUP: begin
        if (count == '0) begin
          state_next = EPULSE;
          count_next = LOAD_EPULSE;
        end else begin
          count_next = count - 1'b1;
        end
      end
      EPULSE: begin
        if (count == '0) begin
          state_next = HOLD;
          count_next = LOAD_HOLD;
        end else begin
          count_next = count - 1'b1;
        end
      end
      HOLD: begin
        if (count == '0) begin
          state_next = DONE;
          count_next = '0;
        end else begin
          count_next = count - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase

    busy_next = (state_next == SETUP) || (state_next == EPULSE) || (state_next == HOLD);
    e_next    = (state_next == EPULSE);
    end_next  = (state_next == DONE);
  end

  // State, counter and pin registers; reset clears everything including a live E pulse.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state      <= IDLE;
      count      <= '0;
      busy       <= 1'b0;
      end_strobe <= 1'b0;
      lcd_e      <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_data   <= 4'h0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      busy       <= busy_next;
      end_strobe <= end_next;
      lcd_e      <= e_next;
      lcd_rs     <= rs_next;
      lcd_data   <= data_next;
    end
  end

endmodule

// File: tb/tb_hd44780_nybble_sender.sv
// Directed bench for hd44780_nybble_sender: default-timing instance "a" and a
// minimum-timing instance "b", checked cycle by cycle against hand-derived
// E / busy / end windows relative to the accepting edge.

module tb_hd44780_nybble_sender;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dat_a, dat_b;
  logic       rs_a, rs_b;
  logic       start_a, start_b;
  logic       busy_a, busy_b;
  logic       end_a, end_b;
  logic       lcd_rs_a, lcd_rs_b;
  logic       lcd_e_a, lcd_e_b;
  logic [3:0] lcd_data_a, lcd_data_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hd44780_nybble_sender dut_a (
    .CLK_I        (clk),
    .RST_I        (rst),
    .DAT_I        (dat_a),
    .rs_i         (rs_a),
    .start_strobe (start_a),
    .busy         (busy_a),
    .end_strobe   (end_a),
    .lcd_rs       (lcd_rs_a),
    .lcd_e        (lcd_e_a),
    .lcd_data     (lcd_data_a)
  );

  hd44780_nybble_sender #(
    .TICKS_TAS   (1),
    .TICKS_PWEH  (1),
    .TICKS_TCYCE (3),
    .COUNT_BITS  (2)
  ) dut_b (
    .CLK_I        (clk),
    .RST_I        (rst),
    .DAT_I        (dat_b),
    .rs_i         (rs_b),
    .start_strobe (start_b),
    .busy         (busy_b),
    .end_strobe   (end_b),
    .lcd_rs       (lcd_rs_b),
    .lcd_e        (lcd_e_b),
    .lcd_data     (lcd_data_b)
  );

  // Advance one clock; afterwards we are inside the next cycle, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected pins of instance a, rel cycles after the accepting edge (rel 0 = idle).
  task automatic check_output(input string tag, input int rel, input logic [3:0] d, input logic r);
    logic e_exp, busy_exp, end_exp;
    e_exp    = (rel >= 4) && (rel <= 25);
    busy_exp = (rel >= 1) && (rel <= 48);
    end_exp  = (rel == 49);
    compare($sformatf("%s.e@%0d", tag, rel),    {3'b0, lcd_e_a}, {3'b0, e_exp});
    compare($sformatf("%s.busy@%0d", tag, rel), {3'b0, busy_a},  {3'b0, busy_exp});
    compare($sformatf("%s.end@%0d", tag, rel),  {3'b0, end_a},   {3'b0, end_exp});
    compare($sformatf("%s.data@%0d", tag, rel), lcd_data_a,      d);
    compare($sformatf("%s.rs@%0d", tag, rel),   {3'b0, lcd_rs_a}, {3'b0, r});
  endtask

  // Drive instance a inputs for the current cycle.
  task automatic apply_stimulus(input logic s, input logic [3:0] d, input logic r);
    start_a = s;
    dat_a   = d;
    rs_a    = r;
  endtask

  initial begin
    rst = 1'b1;
    apply_stimulus(1'b0, 4'h0, 1'b0);
    start_b = 1'b0;
    dat_b   = 4'h0;
    rs_b    = 1'b0;
    tick();
    tick();

    $display("[TB] reset state");
    check_output("rst_a", 0, 4'h0, 1'b0);
    compare("rst_b.e",    {3'b0, lcd_e_b},  4'h0);
    compare("rst_b.busy", {3'b0, busy_b},   4'h0);
    compare("rst_b.end",  {3'b0, end_b},    4'h0);
    compare("rst_b.data", lcd_data_b,       4'h0);
    rst = 1'b0;
    tick();

    // 1: single write of A with RS=1, inputs scrambled after acceptance.
    $display("[TB] single write");
    apply_stimulus(1'b1, 4'hA, 1'b1);
    check_output("t1", 0, 4'h0, 1'b0);
    tick();
    apply_stimulus(1'b0, 4'h0, 1'b0);
    for (int k = 1; k <= 60; k++) begin
      check_output("t1", k, 4'hA, 1'b1);
      tick();
    end

    // 2: back-to-back 3 then C, second start issued in the end_strobe cycle.
    $display("[TB] back-to-back");
    apply_stimulus(1'b1, 4'h3, 1'b0);
    tick();
    apply_stimulus(1'b0, 4'h0, 1'b0);
    for (int k = 1; k <= 49; k++) begin
      check_output("t2a", k, 4'h3, 1'b0);
      if (k < 49) tick();
    end
    apply_stimulus(1'b1, 4'hC, 1'b1);
    tick();
    apply_stimulus(1'b0, 4'h0, 1'b0);
    for (int k = 50; k <= 99; k++) begin
      check_output("t2b", k - 49, 4'hC, 1'b1);
      tick();
    end

    // 3: start during a transaction is ignored.
    $display("[TB] start while busy");
    apply_stimulus(1'b1, 4'h9, 1'b0);
    tick();
    apply_stimulus(1'b0, 4'h0, 1'b0);
    for (int k = 1; k <= 60; k++) begin
      check_output("t3", k, 4'h9, 1'b0);
      if (k == 10) apply_stimulus(1'b1, 4'h5, 1'b1);
      else         apply_stimulus(1'b0, 4'h0, 1'b0);
      tick();
    end

    // 4: reset mid-EPULSE, then a fresh transaction at cycle 20.
    $display("[TB] reset mid-pulse");
    apply_stimulus(1'b1, 4'h6, 1'b1);
    tick();
    apply_stimulus(1'b0, 4'h0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      check_output("t4a", k, 4'h6, 1'b1);
      if (k < 12) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 13; k <= 20; k++) begin
      check_output("t4r", 0, 4'h0, 1'b0);
      if (k < 20) tick();
    end
    apply_stimulus(1'b1, 4'hE, 1'b0);
    tick();
    apply_stimulus(1'b0, 4'h0, 1'b0);
    for (int k = 21; k <= 70; k++) begin
      check_output("t4b", k - 20, 4'hE, 1'b0);
      tick();
    end

    // 5: minimum timing, start held high: one E pulse every 4 cycles.
    $display("[TB] minimum timing");
    start_b = 1'b1;
    dat_b   = 4'h7;
    rs_b    = 1'b1;
    tick();
    for (int k = 1; k <= 12; k++) begin
      int ph;
      ph = ((k - 1) % 4) + 1;
      compare($sformatf("t5.e@%0d", k),    {3'b0, lcd_e_b},  {3'b0, ph == 2});
      compare($sformatf("t5.busy@%0d", k), {3'b0, busy_b},   {3'b0, ph <= 3});
      compare($sformatf("t5.end@%0d", k),  {3'b0, end_b},    {3'b0, ph == 4});
      compare($sformatf("t5.data@%0d", k), lcd_data_b,       4'h7);
      compare($sformatf("t5.rs@%0d", k),   {3'b0, lcd_rs_b}, 4'h1);
      tick();
    end
    start_b = 1'b0;

    // 6: start held high with DAT_I counting; nybbles from cycles 0, 49, 98.
    $display("[TB] continuous start");
    for (int k = 0; k <= 147; k++) begin
      logic [3:0] d_exp;
      int         idx;
      if (k >= 1) begin
        idx   = (k - 1) / 49;
        d_exp = 4'((idx * 49) % 16);
        check_output("t6", ((k - 1) % 49) + 1, d_exp, 1'b1);
      end
      apply_stimulus(1'b1, 4'(k % 16), 1'b1);
      tick();
    end
    apply_stimulus(1'b0, 4'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
